btn_debounce_ctrl: RTL and testbench
====================================

BTN_DEBOUNCE_CTRL -- requirements
Module: btn_debounce_ctrl

Interface
REQ-001 Parameter N_BTN, default 4: number of independent button channels, legal range 1..8.
REQ-002 Parameter STABLE_TICKS, default 3: consecutive agreeing ticks needed to accept a level change, legal range 2..7.
REQ-003 clk  input  1  system clock; all logic on the rising edge; one clock domain.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 rtg_in  input  1  rate-generator MSB level; each rising edge is one sample tick (nominally every 2.62 ms).
REQ-006 btn_in  input  N_BTN  raw, asynchronous, bouncing button levels; 1 = pressed.
REQ-007 btn_level  output  N_BTN  debounced button state, registered.
REQ-008 btn_press  output  N_BTN  one-cycle pulse per accepted 0->1 transition, registered.
REQ-009 btn_release  output  N_BTN  one-cycle pulse per accepted 1->0 transition, registered.

Function
REQ-010 Each btn_in bit SHALL pass through a 2-flop synchronizer; only the second-stage output ("sample") feeds the channel FSM.
REQ-011 rtg_in SHALL be registered once (rtg_q); tick = rtg_in & ~rtg_q, combinational, high for exactly one cycle per rtg_in rising edge.
REQ-012 A single tick SHALL be shared by all channels; every channel evaluates its sample on the same tick cycle; no round-robin.
REQ-013 Each channel SHALL own a 4-state FSM: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND, plus a 3-bit agreement counter cnt.
REQ-014 RELEASED: on tick with sample=1 -> PRESS_PEND, cnt<=1; otherwise hold.
REQ-015 PRESS_PEND: on tick with sample=0 -> RELEASED, cnt<=0; on tick with sample=1 and cnt==STABLE_TICKS-1 -> PRESSED, cnt<=0; on tick with sample=1 otherwise -> cnt<=cnt+1.
REQ-016 PRESSED: on tick with sample=0 -> RELEASE_PEND, cnt<=1; otherwise hold.
REQ-017 RELEASE_PEND: on tick with sample=1 -> PRESSED, cnt<=0; on tick with sample=0 and cnt==STABLE_TICKS-1 -> RELEASED, cnt<=0; on tick with sample=0 otherwise -> cnt<=cnt+1.
REQ-018 Without a tick, FSM and cnt SHALL hold regardless of sample activity.
REQ-019 btn_level SHALL be 1 exactly when the FSM is in PRESSED or RELEASE_PEND, and SHALL be registered so it changes in the cycle after the accepting tick.
REQ-020 btn_press SHALL be high for one cycle, in the same cycle btn_level rises; btn_release likewise, in the same cycle btn_level falls.
REQ-021 Latency: a clean edge held stable is accepted on the STABLE_TICKS-th tick whose sample reflects it; level/pulse appear one cycle later.
REQ-022 Any disagreeing sample inside a PEND state SHALL abort to the prior stable state; no pulse, btn_level unchanged.
REQ-023 Several channels accepting on the same tick SHALL pulse simultaneously in the same cycle.
REQ-024 cnt SHALL never exceed STABLE_TICKS-1; no wrap-around.

Reset
REQ-025 While rst=1: all FSMs RELEASED, cnt=0, synchronizer flops 0, btn_level=0, btn_press=0, btn_release=0.
REQ-026 rtg_q SHALL reset to 1, so an rtg_in already high at reset release produces no tick.
REQ-027 rst asserted mid-debounce SHALL discard the pending state with no pulse; a button held through reset release is re-debounced from RELEASED and yields one btn_press.

Verification
REQ-028 STABLE_TICKS=3, btn_in[0]=1 held, 3 ticks -> btn_level[0]=1 and btn_press[0]=1 for one cycle in the cycle after the 3rd tick; no pulse after ticks 1-2.
REQ-029 btn_in[1] sampled 1,1,0 on three ticks -> btn_level[1] stays 0, no btn_press; then 1,1,1 -> press after the 3rd.
REQ-030 Pressed channel, btn_in=0 for 3 ticks -> btn_level falls and btn_release pulses once; a 1 on tick 2 aborts, level stays 1.
REQ-031 btn_in toggling every cycle with rtg_in held constant for 1000 cycles -> no output change (no ticks).
REQ-032 btn_in=4'b1010 applied simultaneously, 3 ticks -> btn_press=4'b1010 in a single cycle.
REQ-033 rst pulsed while rtg_in=1 and btn_in[0]=1 in PRESS_PEND -> outputs 0, no tick on release; 3 subsequent ticks -> one btn_press[0].

Source files
------------

// File: rtl/btn_debounce_ctrl.sv
// Multi-channel push-button debouncer: 2-flop synchronizers, a shared sample tick
// derived from the rate-generator MSB, and one 4-state agreement FSM per channel.
//
// state        | meaning
// RELEASED     | stable released, btn_level = 0
// PRESS_PEND   | counting agreeing pressed samples, btn_level = 0
// PRESSED      | stable pressed, btn_level = 1
// RELEASE_PEND | counting agreeing released samples, btn_level = 1
module btn_debounce_ctrl #(
  parameter int N_BTN        = 4,
  parameter int STABLE_TICKS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rtg_in,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'(STABLE_TICKS - 1);

  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sample_q, sample_d;
  logic             rtg_q, rtg_d;
  logic             tick;

  state_t           state_q [N_BTN];
  state_t           state_d [N_BTN];
  logic [2:0]       cnt_q   [N_BTN];
  logic [2:0]       cnt_d   [N_BTN];

  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;

  always_comb begin
    sync1_d  = btn_in;
    sample_d = sync1_q;
    rtg_d    = rtg_in;
    tick     = rtg_in & ~rtg_q;
  end

  always_comb begin
    level_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (tick) begin
        case (state_q[i])
          RELEASED: begin
            if (sample_q[i]) begin
              state_d[i] = PRESS_PEND;
              cnt_d[i]   = 3'd1;
            end
          end
          PRESS_PEND: begin
            if (!sample_q[i]) begin
              state_d[i] = RELEASED;
              cnt_d[i]   = 3'd0;
            end else if (cnt_q[i] >= CNT_LAST) begin
              state_d[i] = PRESSED;
              cnt_d[i]   = 3'd0;
            end else begin
              cnt_d[i] = cnt_q[i] + 3'd1;
            end
          end
          PRESSED: begin
            if (!sample_q[i]) begin
              state_d[i] = RELEASE_PEND;
              cnt_d[i]   = 3'd1;
            end
          end
          RELEASE_PEND: begin
            if (sample_q[i]) begin
              state_d[i] = PRESSED;
              cnt_d[i]   = 3'd0;
            end else if (cnt_q[i] >= CNT_LAST) begin
              state_d[i] = RELEASED;
              cnt_d[i]   = 3'd0;
            end else begin
              cnt_d[i] = cnt_q[i] + 3'd1;
            end
          end
          default: begin
            state_d[i] = RELEASED;
            cnt_d[i]   = 3'd0;
          end
        endcase
      end
      level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_PEND);
    end
    // level_q always mirrors the registered state, so edges of level_d are the accepts
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sample_q  <= '0;
      rtg_q     <= 1'b1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= 3'd0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sample_q  <= sample_d;
      rtg_q     <= rtg_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Directed bench for btn_debounce_ctrl (N_BTN=4, STABLE_TICKS=3); expected output
// triples are queued as each step is driven and popped when the DUT is sampled.
module tb_btn_debounce_ctrl;

  logic       clk;
  logic       rst;
  logic       rtg_in;
  logic [3:0] btn_in;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
  } exp_t;

  exp_t exp_q[$];
  int   assert_cnt = 0;
  int   fail_cnt   = 0;

  btn_debounce_ctrl #(.N_BTN(4), .STABLE_TICKS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .rtg_in      (rtg_in),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input logic [3:0] lvl, input logic [3:0] prs, input logic [3:0] rel);
    exp_t e;
    e.lvl = lvl;
    e.prs = prs;
    e.rel = rel;
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    exp_t obs;
    e       = exp_q.pop_front();
    obs.lvl = btn_level;
    obs.prs = btn_press;
    obs.rel = btn_release;
    assert_cnt++;
    assert (obs === e) else begin
      fail_cnt++;
      $error("FAIL %s: observed lvl=%b prs=%b rel=%b expected lvl=%b prs=%b rel=%b",
             tag, obs.lvl, obs.prs, obs.rel, e.lvl, e.prs, e.rel);
    end
  endtask

  // One rtg_in rising edge; checks the cycle after the tick and the one after that.
  task automatic do_tick(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                         input logic [3:0] rel);
    expect_out(lvl, prs, rel);
    expect_out(lvl, 4'b0000, 4'b0000);
    @(negedge clk) rtg_in = 1'b1;
    @(negedge clk);
    check(tag);
    rtg_in = 1'b0;
    @(negedge clk);
    check({tag, "_next"});
  endtask

  task automatic set_btn(input logic [3:0] v);
    btn_in = v;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    rtg_in = 1'b0;
    btn_in = 4'b0000;
    repeat (3) @(negedge clk);
    expect_out(4'b0000, 4'b0000, 4'b0000);
    check("reset");
    rst = 1'b0;
    @(negedge clk);

    // Clean press on channel 0
    set_btn(4'b0001);
    do_tick("c0_tick1", 4'b0000, 4'b0000, 4'b0000);
    do_tick("c0_tick2", 4'b0000, 4'b0000, 4'b0000);
    do_tick("c0_tick3", 4'b0001, 4'b0001, 4'b0000);

    // Channel 1 sees 1,1,0 (abort), then 1,1,1
    set_btn(4'b0011);
    do_tick("c1_a1", 4'b0001, 4'b0000, 4'b0000);
    do_tick("c1_a2", 4'b0001, 4'b0000, 4'b0000);
    set_btn(4'b0001);
    do_tick("c1_abort", 4'b0001, 4'b0000, 4'b0000);
    set_btn(4'b0011);
    do_tick("c1_b1", 4'b0001, 4'b0000, 4'b0000);
    do_tick("c1_b2", 4'b0001, 4'b0000, 4'b0000);
    do_tick("c1_b3", 4'b0011, 4'b0010, 4'b0000);

    // Channel 0 release aborted on tick 2, then a clean release
    set_btn(4'b0010);
    do_tick("c0_r1", 4'b0011, 4'b0000, 4'b0000);
    set_btn(4'b0011);
    do_tick("c0_rabort", 4'b0011, 4'b0000, 4'b0000);
    do_tick("c0_rhold", 4'b0011, 4'b0000, 4'b0000);
    set_btn(4'b0010);
    do_tick("c0_r1b", 4'b0011, 4'b0000, 4'b0000);
    do_tick("c0_r2b", 4'b0011, 4'b0000, 4'b0000);
    do_tick("c0_r3b", 4'b0010, 4'b0000, 4'b0001);

    // No ticks: bouncing inputs must not move anything
    rtg_in = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      expect_out(4'b0010, 4'b0000, 4'b0000);
      if (i % 100 == 99) check("no_tick");
      else void'(exp_q.pop_front());
      btn_in = ~btn_in;
    end
    set_btn(4'b0010);
    expect_out(4'b0010, 4'b0000, 4'b0000);
    check("no_tick_end");

    // Release channel 1, then simultaneous press on channels 3 and 1
    set_btn(4'b0000);
    do_tick("rel1_1", 4'b0010, 4'b0000, 4'b0000);
    do_tick("rel1_2", 4'b0010, 4'b0000, 4'b0000);
    do_tick("rel1_3", 4'b0000, 4'b0000, 4'b0010);
    set_btn(4'b1010);
    do_tick("multi_1", 4'b0000, 4'b0000, 4'b0000);
    do_tick("multi_2", 4'b0000, 4'b0000, 4'b0000);
    do_tick("multi_3", 4'b1010, 4'b1010, 4'b0000);
    set_btn(4'b0000);
    do_tick("mrel_1", 4'b1010, 4'b0000, 4'b0000);
    do_tick("mrel_2", 4'b1010, 4'b0000, 4'b0000);
    do_tick("mrel_3", 4'b0000, 4'b0000, 4'b1010);

    // Reset during PRESS_PEND with rtg_in high; held button re-debounced afterwards
    set_btn(4'b0001);
    do_tick("pend_1", 4'b0000, 4'b0000, 4'b0000);
    do_tick("pend_2", 4'b0000, 4'b0000, 4'b0000);
    rtg_in = 1'b1;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    expect_out(4'b0000, 4'b0000, 4'b0000);
    check("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      expect_out(4'b0000, 4'b0000, 4'b0000);
      check("rst_release_no_tick");
    end
    rtg_in = 1'b0;
    @(negedge clk);
    do_tick("post_rst_1", 4'b0000, 4'b0000, 4'b0000);
    do_tick("post_rst_2", 4'b0000, 4'b0000, 4'b0000);
    do_tick("post_rst_3", 4'b0001, 4'b0001, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
